// File: rtl/four_bit_mag_pkg.sv
// Shared constants, result encoding and output mapping for the four_bit_mag comparator.
// Cascade inputs are enabled in the top with FOUR_BIT_MAG_CASCADE_EN.
package four_bit_mag_pkg;

    localparam int MAG_WIDTH = 4;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_LT,
        RES_EQ,
        RES_GT
    } mag_result_e;

    // Bit order is {less, equal, greater}; RES_NONE is the reset-only all-zero state.
    function automatic logic [2:0] resultToBits(input mag_result_e res);
        logic [2:0] bits;
        bits = 3'b000;
        case (res)
            RES_LT:  bits = 3'b100;
            RES_EQ:  bits = 3'b010;
            RES_GT:  bits = 3'b001;
            default: bits = 3'b000;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/mag_bit_slice.sv
// One bit position of the magnitude comparator: reports whether the bit pair
// matches and whether the A bit is the larger one.
module mag_bit_slice (
    input  logic i_a,
    input  logic i_b,
    output logic o_eq,
    output logic o_gt
);

    assign o_eq = ~(i_a ^ i_b);
    assign o_gt = i_a & ~i_b;

endmodule

// File: rtl/four_bit_mag.sv
// Registered 4-bit unsigned magnitude comparator with one-cycle latency.
// Define FOUR_BIT_MAG_CASCADE_EN to add 7485-style lt_in/eq_in/gt_in chaining inputs.
module four_bit_mag
    import four_bit_mag_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAG_WIDTH-1:0] A,
    input  logic [MAG_WIDTH-1:0] B,
`ifdef FOUR_BIT_MAG_CASCADE_EN
    input  logic                 lt_in,
    input  logic                 eq_in,
    input  logic                 gt_in,
`endif
    output logic                 less,
    output logic                 equal,
    output logic                 greater
);

    logic [MAG_WIDTH-1:0] w_bitEq;
    logic [MAG_WIDTH-1:0] w_bitGt;
    mag_result_e          w_local;
    mag_result_e          w_result;
    logic [2:0]           r_result;

    for (genvar g = 0; g < MAG_WIDTH; g++) begin : g_slice
        mag_bit_slice u_slice (
            .i_a  (A[g]),
            .i_b  (B[g]),
            .o_eq (w_bitEq[g]),
            .o_gt (w_bitGt[g])
        );
    end

    // Scanning upward lets the highest differing bit overwrite any lower decision.
    always_comb begin
        w_local = RES_EQ;
        for (int i = 0; i < MAG_WIDTH; i++) begin
            if (!w_bitEq[i]) begin
                w_local = w_bitGt[i] ? RES_GT : RES_LT;
            end
        end
    end

`ifdef FOUR_BIT_MAG_CASCADE_EN
    // Ties defer to the lower-order stage, gt_in winning over lt_in over eq_in.
    always_comb begin
        w_result = w_local;
        if (w_local == RES_EQ) begin
            if (gt_in)      w_result = RES_GT;
            else if (lt_in) w_result = RES_LT;
            else            w_result = RES_EQ;
        end
    end

    logic w_eqInUnused;
    assign w_eqInUnused = eq_in;
`else
    assign w_result = w_local;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= resultToBits(RES_NONE);
        end else begin
            r_result <= resultToBits(w_result);
        end
    end

    assign {less, equal, greater} = r_result;

endmodule

// File: tb/tb_four_bit_mag.sv
// Self-checking bench for four_bit_mag: directed table, exhaustive sweep, randomized
// traffic against an arithmetic reference model, and cascade cases under FOUR_BIT_MAG_CASCADE_EN.
module tb_four_bit_mag;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       less;
    logic       equal;
    logic       greater;
`ifdef FOUR_BIT_MAG_CASCADE_EN
    logic       ltIn;
    logic       eqIn;
    logic       gtIn;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[8];

    four_bit_mag dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
`ifdef FOUR_BIT_MAG_CASCADE_EN
        .lt_in   (ltIn),
        .eq_in   (eqIn),
        .gt_in   (gtIn),
`endif
        .less    (less),
        .equal   (equal),
        .greater (greater)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference relation computed from plain unsigned arithmetic, {less, equal, greater}.
    function automatic logic [2:0] refCompare(input int a, input int b);
        if (a < b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic r);
        A   = a;
        B   = b;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] exp);
        logic [2:0] act;
        act = {less, equal, greater};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got {lt,eq,gt}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic checkOneHot(input string name);
        logic [2:0] act;
        act = {less, equal, greater};
        checks++;
        if ($countones(act) != 1) begin
            failures++;
            $display("[TB] FAIL %s: got {lt,eq,gt}=%b expected exactly one bit set", name, act);
        end
    endtask

    initial begin
        logic [2:0] prevExp;
        logic [2:0] exp;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rr;

        checks   = 0;
        failures = 0;
        A        = 4'd0;
        B        = 4'd0;
        rst      = 1'b1;
`ifdef FOUR_BIT_MAG_CASCADE_EN
        ltIn = 1'b0;
        eqIn = 1'b0;
        gtIn = 1'b0;
`endif

        vecs[0] = '{a: 4'd1,  b: 4'd4,  exp: 3'b100};
        vecs[1] = '{a: 4'd5,  b: 4'd4,  exp: 3'b001};
        vecs[2] = '{a: 4'd1,  b: 4'd12, exp: 3'b100};
        vecs[3] = '{a: 4'd3,  b: 4'd4,  exp: 3'b100};
        vecs[4] = '{a: 4'd0,  b: 4'd0,  exp: 3'b010};
        vecs[5] = '{a: 4'd15, b: 4'd0,  exp: 3'b001};
        vecs[6] = '{a: 4'd0,  b: 4'd15, exp: 3'b100};
        vecs[7] = '{a: 4'd15, b: 4'd15, exp: 3'b010};

        $display("[TB] reset sequence");
        applyStimulus(4'd0, 4'd0, 1'b1);
        checkOutput("reset_cycle1", 3'b000);
        applyStimulus(4'd0, 4'd0, 1'b1);
        checkOutput("reset_cycle2", 3'b000);
        applyStimulus(4'd0, 4'd0, 1'b0);
        checkOutput("first_after_reset", 3'b010);

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1'b0);
            checkOutput($sformatf("vec%0d_a%0d_b%0d", i, vecs[i].a, vecs[i].b), vecs[i].exp);
        end

        // Inputs change well before the edge; outputs must hold the previous result until it.
        $display("[TB] exhaustive sweep");
        prevExp = vecs[7].exp;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                A = 4'(a);
                B = 4'(b);
                #1;
                checkOutput($sformatf("hold_a%0d_b%0d", a, b), prevExp);
                @(posedge clk);
                #1;
                exp = refCompare(a, b);
                checkOutput($sformatf("sweep_a%0d_b%0d", a, b), exp);
                checkOneHot($sformatf("onehot_a%0d_b%0d", a, b));
                prevExp = exp;
            end
        end

        $display("[TB] mid-stream reset");
        applyStimulus(4'd9, 4'd2, 1'b1);
        checkOutput("midreset_asserted", 3'b000);
        applyStimulus(4'd9, 4'd2, 1'b0);
        checkOutput("midreset_released", 3'b001);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 11) == 0);
            applyStimulus(ra, rb, rr);
            exp = rr ? 3'b000 : refCompare(int'(ra), int'(rb));
            checkOutput($sformatf("rand%0d_a%0d_b%0d_r%0d", n, ra, rb, rr), exp);
        end

`ifdef FOUR_BIT_MAG_CASCADE_EN
        $display("[TB] cascade inputs");
        ltIn = 1'b0; eqIn = 1'b0; gtIn = 1'b1;
        applyStimulus(4'd7, 4'd7, 1'b0);
        checkOutput("casc_eq_gtin", 3'b001);
        ltIn = 1'b1; eqIn = 1'b1; gtIn = 1'b0;
        applyStimulus(4'd7, 4'd7, 1'b0);
        checkOutput("casc_eq_ltin_eqin", 3'b100);
        ltIn = 1'b0; eqIn = 1'b0; gtIn = 1'b0;
        applyStimulus(4'd7, 4'd7, 1'b0);
        checkOutput("casc_eq_none", 3'b010);
        ltIn = 1'b1; eqIn = 1'b0; gtIn = 1'b0;
        applyStimulus(4'd8, 4'd7, 1'b0);
        checkOutput("casc_local_gt", 3'b001);
        ltIn = 1'b1; eqIn = 1'b0; gtIn = 1'b1;
        applyStimulus(4'd2, 4'd2, 1'b0);
        checkOutput("casc_gt_over_lt", 3'b001);
        ltIn = 1'b0; eqIn = 1'b0; gtIn = 1'b1;
        applyStimulus(4'd2, 4'd9, 1'b0);
        checkOutput("casc_local_lt", 3'b100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
